rst_sequencer: RTL and testbench

Ordered reset-release sequencer for one clock domain. It sits directly downstream of the power-on reset pulse generator, whose inverted output drives `async_rst_n`. It waits for a clock-source lock indication to be stable, then releases `NUM_STAGES` subsystem resets one at a time, spaced by a programmable delay. Loss of lock or a soft reset request re-asserts every stage reset immediately.

---
 rtl/rst_pkg.sv | 25 ++
 rtl/rst_sequencer_sync_bit.sv | 30 +++
 rtl/rst_sequencer.sv | 138 +++++++++++++
 tb/tb_rst_sequencer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rst_pkg.sv
// ----------------------------------------------------------------------------
// rst_pkg
// Shared definitions for the reset-tree blocks.
//   rst_state_t : sequencer state encodings (HOLD, FILTER, RELEASE, RUN)
//   clog2()     : ceil(log2(value)) with a floor of 1 bit, for sizing counters
// ----------------------------------------------------------------------------
package rst_pkg;

   typedef enum logic [1:0] {
      RST_HOLD    = 2'd0,
      RST_FILTER  = 2'd1,
      RST_RELEASE = 2'd2,
      RST_RUN     = 2'd3
   } rst_state_t;

   // A counter that must hold the values 0..value-1 never needs more than
   // this many bits; a 1-bit floor keeps degenerate parameters legal.
   function automatic int clog2(input int value);
      int w;
      w = 1;
      while ((1 << w) < value) w++;
      return w;
   endfunction

endpackage

// File: rtl/rst_sequencer_sync_bit.sv
// ----------------------------------------------------------------------------
// sync_bit
// Multi-flop synchronizer for a single asynchronous level signal.
//   clk   : destination clock
//   rst_n : asynchronous active-low clear, forces every flop to 0
//   d     : asynchronous input
//   q     : input after SYNC_STAGES flops
// ----------------------------------------------------------------------------
module sync_bit #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_ff;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_ff <= '0;
      end else begin
         sync_ff <= {sync_ff[SYNC_STAGES-2:0], d};
      end
   end

   assign q = sync_ff[SYNC_STAGES-1];

endmodule

// File: rtl/rst_sequencer.sv
// ----------------------------------------------------------------------------
// rst_sequencer
// Ordered reset-release sequencer. Waits for a filtered clock-lock
// indication, then releases NUM_STAGES subsystem resets one at a time
// (bit 0 first) spaced by STAGE_DLY cycles. Loss of lock or soft_rst
// re-asserts every stage at once.
//   clk          : sole clock
//   async_rst_n  : asynchronous active-low reset
//   locked       : asynchronous PLL/MMCM lock status
//   soft_rst     : synchronous level request, high holds all stages in reset
//   stage_rst    : registered active-high stage resets
//   all_released : high when every stage is released (state RUN)
//   seq_state    : current state encoding for debug
// ----------------------------------------------------------------------------
module rst_sequencer
   import rst_pkg::*;
#(
   parameter int NUM_STAGES  = 4,
   parameter int STAGE_DLY   = 16,
   parameter int LOCK_FILT   = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  async_rst_n,
   input  logic                  locked,
   input  logic                  soft_rst,
   output logic [NUM_STAGES-1:0] stage_rst,
   output logic                  all_released,
   output logic [1:0]            seq_state
);

   localparam int CNT_W = clog2(LOCK_FILT);
   localparam int DLY_W = clog2(STAGE_DLY);
   localparam int IDX_W = clog2(NUM_STAGES);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_FILT - 1);
   localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(STAGE_DLY - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_STAGES - 1);

   rst_state_t            state, state_nxt;
   logic [CNT_W-1:0]      cnt, cnt_nxt;
   logic [DLY_W-1:0]      dly, dly_nxt;
   logic [IDX_W-1:0]      idx, idx_nxt;
   logic [NUM_STAGES-1:0] stage_rst_nxt;
   logic                  all_released_nxt;
   logic                  locked_s;
   logic                  ok;

   sync_bit #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_lock_sync (
      .clk   (clk),
      .rst_n (async_rst_n),
      .d     (locked),
      .q     (locked_s)
   );

   assign ok = locked_s & ~soft_rst;

   always_ff @(posedge clk or negedge async_rst_n) begin
      if (!async_rst_n) begin
         state        <= RST_HOLD;
         cnt          <= '0;
         dly          <= '0;
         idx          <= '0;
         stage_rst    <= '1;
         all_released <= 1'b0;
      end else begin
         state        <= state_nxt;
         cnt          <= cnt_nxt;
         dly          <= dly_nxt;
         idx          <= idx_nxt;
         stage_rst    <= stage_rst_nxt;
         all_released <= all_released_nxt;
      end
   end

   always_comb begin
      state_nxt        = state;
      cnt_nxt          = cnt;
      dly_nxt          = dly;
      idx_nxt          = idx;
      stage_rst_nxt    = stage_rst;
      all_released_nxt = all_released;

      // Abort wins over every other transition, including a release edge.
      if (!ok) begin
         state_nxt        = RST_HOLD;
         cnt_nxt          = '0;
         dly_nxt          = '0;
         idx_nxt          = '0;
         stage_rst_nxt    = '1;
         all_released_nxt = 1'b0;
      end else begin
         unique case (state)
            RST_HOLD: begin
               state_nxt     = RST_FILTER;
               cnt_nxt       = '0;
               stage_rst_nxt = '1;
            end
            RST_FILTER: begin
               if (cnt == CNT_LAST) begin
                  state_nxt = RST_RELEASE;
                  dly_nxt   = '0;
                  idx_nxt   = '0;
               end else begin
                  cnt_nxt = cnt + CNT_W'(1);
               end
            end
            RST_RELEASE: begin
               if (dly == DLY_LAST) begin
                  for (int i = 0; i < NUM_STAGES; i++) begin
                     if (idx == IDX_W'(i)) stage_rst_nxt[i] = 1'b0;
                  end
                  dly_nxt = '0;
                  // idx saturates on the last stage rather than wrapping.
                  if (idx == IDX_LAST) begin
                     state_nxt        = RST_RUN;
                     all_released_nxt = 1'b1;
                  end else begin
                     idx_nxt = idx + IDX_W'(1);
                  end
               end else begin
                  dly_nxt = dly + DLY_W'(1);
               end
            end
            RST_RUN: begin
            end
            default: begin
               state_nxt = RST_HOLD;
            end
         endcase
      end
   end

   assign seq_state = state;

endmodule

// File: tb/tb_rst_sequencer.sv
// ----------------------------------------------------------------------------
// tb_rst_sequencer
// Directed testbench for rst_sequencer. dut uses default parameters;
// dut_small uses NUM_STAGES=1, STAGE_DLY=1 with its own reset.
// ----------------------------------------------------------------------------
module tb_rst_sequencer;

   logic       clk;
   logic       rst_n;
   logic       rst_n2;
   logic       locked;
   logic       soft_rst;
   logic [3:0] stage_rst;
   logic       all_released;
   logic [1:0] seq_state;
   logic [0:0] stage_rst2;
   logic       all_released2;
   logic [1:0] seq_state2;

   int checks = 0;
   int errors = 0;

   rst_sequencer dut (
      .clk          (clk),
      .async_rst_n  (rst_n),
      .locked       (locked),
      .soft_rst     (soft_rst),
      .stage_rst    (stage_rst),
      .all_released (all_released),
      .seq_state    (seq_state)
   );

   rst_sequencer #(
      .NUM_STAGES (1),
      .STAGE_DLY  (1)
   ) dut_small (
      .clk          (clk),
      .async_rst_n  (rst_n2),
      .locked       (locked),
      .soft_rst     (soft_rst),
      .stage_rst    (stage_rst2),
      .all_released (all_released2),
      .seq_state    (seq_state2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Leaves both DUTs just released from reset; the next rising edge is edge 1.
   task automatic do_reset(input logic lock_val);
      rst_n    = 1'b0;
      rst_n2   = 1'b0;
      soft_rst = 1'b0;
      locked   = lock_val;
      step(3);
      rst_n  = 1'b1;
      rst_n2 = 1'b1;
   endtask

   // Default-parameter timeline, edge e counted from when locked_s can first
   // be seen high: stage k releases at 27 + 16k.
   function automatic logic [3:0] exp_nom(input int e);
      logic [3:0] r;
      for (int k = 0; k < 4; k++) r[k] = (e < 27 + 16 * k);
      return r;
   endfunction

   function automatic logic [1:0] exp_state(input int e);
      if (e < 3)  return 2'd0;
      if (e < 11) return 2'd1;
      if (e < 75) return 2'd2;
      return 2'd3;
   endfunction

   task automatic test_reset();
      rst_n = 1'b0; rst_n2 = 1'b0; locked = 1'b1; soft_rst = 1'b0;
      step(4);
      checks++;
      if (stage_rst !== 4'hF || all_released !== 1'b0 || seq_state !== 2'd0) begin
         errors++;
         $display("FAIL reset_hold: stage_rst=%b all_released=%b state=%0d, required 1111/0/0",
                  stage_rst, all_released, seq_state);
      end
      do_reset(1'b1);
      step(30);
      checks++;
      if (stage_rst !== 4'b1110) begin
         errors++;
         $display("FAIL reset_pre: stage_rst=%b, required 1110", stage_rst);
      end
      #3 rst_n = 1'b0;
      #1;
      checks++;
      if (stage_rst !== 4'hF || all_released !== 1'b0 || seq_state !== 2'd0) begin
         errors++;
         $display("FAIL reset_async: stage_rst=%b all_released=%b state=%0d, required 1111/0/0",
                  stage_rst, all_released, seq_state);
      end
   endtask

   task automatic test_nominal();
      do_reset(1'b1);
      for (int e = 1; e <= 80; e++) begin
         step(1);
         checks++;
         if (stage_rst !== exp_nom(e) || seq_state !== exp_state(e) ||
             all_released !== (e >= 75)) begin
            errors++;
            $display("FAIL nominal edge %0d: stage_rst=%b state=%0d all=%b, required %b/%0d/%b",
                     e, stage_rst, seq_state, all_released, exp_nom(e), exp_state(e), e >= 75);
         end
      end
   endtask

   task automatic test_lock_late();
      do_reset(1'b0);
      for (int e = 1; e <= 100; e++) begin
         step(1);
         checks++;
         if (stage_rst !== 4'hF || seq_state !== 2'd0) begin
            errors++;
            $display("FAIL lock_late_hold edge %0d: stage_rst=%b state=%0d, required 1111/0",
                     e, stage_rst, seq_state);
         end
      end
      locked = 1'b1;
      for (int j = 1; j <= 80; j++) begin
         step(1);
         checks++;
         if (stage_rst !== exp_nom(j) || seq_state !== exp_state(j) ||
             all_released !== (j >= 75)) begin
            errors++;
            $display("FAIL lock_late edge +%0d: stage_rst=%b state=%0d all=%b, required %b/%0d/%b",
                     j, stage_rst, seq_state, all_released, exp_nom(j), exp_state(j), j >= 75);
         end
      end
   endtask

   task automatic test_filter_glitch();
      do_reset(1'b1);
      step(8);
      locked = 1'b0;
      step(2);
      checks++;
      if (seq_state !== 2'd1) begin
         errors++;
         $display("FAIL glitch_filter: state=%0d, required 1", seq_state);
      end
      step(1);
      checks++;
      if (seq_state !== 2'd0 || stage_rst !== 4'hF) begin
         errors++;
         $display("FAIL glitch_abort: state=%0d stage_rst=%b, required 0/1111",
                  seq_state, stage_rst);
      end
      locked = 1'b1;
      for (int j = 1; j <= 40; j++) begin
         step(1);
         checks++;
         if (stage_rst !== exp_nom(j) || seq_state !== exp_state(j)) begin
            errors++;
            $display("FAIL glitch_restart edge +%0d: stage_rst=%b state=%0d, required %b/%0d",
                     j, stage_rst, seq_state, exp_nom(j), exp_state(j));
         end
      end
   endtask

   task automatic test_soft_run();
      do_reset(1'b1);
      step(80);
      checks++;
      if (seq_state !== 2'd3 || stage_rst !== 4'h0) begin
         errors++;
         $display("FAIL soft_run_pre: state=%0d stage_rst=%b, required 3/0000",
                  seq_state, stage_rst);
      end
      soft_rst = 1'b1;
      step(1);
      soft_rst = 1'b0;
      checks++;
      if (stage_rst !== 4'hF || all_released !== 1'b0 || seq_state !== 2'd0) begin
         errors++;
         $display("FAIL soft_run_abort: stage_rst=%b all=%b state=%0d, required 1111/0/0",
                  stage_rst, all_released, seq_state);
      end
      for (int j = 1; j <= 75; j++) begin
         step(1);
         checks++;
         if (stage_rst !== exp_nom(j + 2) || seq_state !== exp_state(j + 2) ||
             all_released !== (j >= 73)) begin
            errors++;
            $display("FAIL soft_run_reseq edge +%0d: stage_rst=%b state=%0d all=%b, required %b/%0d/%b",
                     j, stage_rst, seq_state, all_released, exp_nom(j + 2), exp_state(j + 2), j >= 73);
         end
      end
   endtask

   task automatic test_soft_on_release();
      do_reset(1'b1);
      step(58);
      checks++;
      if (stage_rst !== 4'b1100) begin
         errors++;
         $display("FAIL soft_rel_pre: stage_rst=%b, required 1100", stage_rst);
      end
      soft_rst = 1'b1;
      step(1);
      soft_rst = 1'b0;
      checks++;
      if (stage_rst !== 4'hF || seq_state !== 2'd0 || all_released !== 1'b0) begin
         errors++;
         $display("FAIL soft_rel_abort: stage_rst=%b state=%0d all=%b, required 1111/0/0",
                  stage_rst, seq_state, all_released);
      end
      step(1);
      checks++;
      if (stage_rst !== 4'hF || seq_state !== 2'd1) begin
         errors++;
         $display("FAIL soft_rel_refilter: stage_rst=%b state=%0d, required 1111/1",
                  stage_rst, seq_state);
      end
   endtask

   task automatic test_async_small();
      do_reset(1'b1);
      step(11);
      checks++;
      if (seq_state2 !== 2'd2 || stage_rst2 !== 1'b1) begin
         errors++;
         $display("FAIL small_pre: state=%0d stage_rst=%b, required 2/1", seq_state2, stage_rst2);
      end
      #2 rst_n2 = 1'b0;
      #1;
      checks++;
      if (stage_rst2 !== 1'b1 || seq_state2 !== 2'd0 || all_released2 !== 1'b0) begin
         errors++;
         $display("FAIL small_async: stage_rst=%b state=%0d all=%b, required 1/0/0",
                  stage_rst2, seq_state2, all_released2);
      end
      step(2);
      rst_n2 = 1'b1;
      for (int e = 1; e <= 14; e++) begin
         logic [1:0] es;
         step(1);
         es = (e < 3) ? 2'd0 : (e < 11) ? 2'd1 : (e == 11) ? 2'd2 : 2'd3;
         checks++;
         if (stage_rst2 !== (e < 12) || all_released2 !== (e >= 12) || seq_state2 !== es) begin
            errors++;
            $display("FAIL small_seq edge %0d: stage_rst=%b all=%b state=%0d, required %b/%b/%0d",
                     e, stage_rst2, all_released2, seq_state2, e < 12, e >= 12, es);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0; rst_n2 = 1'b0; locked = 1'b0; soft_rst = 1'b0;
      test_reset();
      test_nominal();
      test_lock_late();
      test_filter_glitch();
      test_soft_run();
      test_soft_on_release();
      test_async_small();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
